spi_slave_frame: RTL and testbench

- SPI mode-0 slave front-end. Oversamples SCK, CS_n and MOSI in the system clock domain and parses frames into a command byte followed by data bytes.
- Drives the 2-bit register-port select (o_addr) into the existing slave mux.
- Shifts mux read data out on MISO and presents received write bytes with strobes.
- Sits between the external SPI pins and the slave-port mux/register blocks.

---
 rtl/spi_slave_frame.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave front-end: oversamples SCK/CS_n/MOSI in i_clk and parses a command byte
// (R/W + port) followed by data bytes, driving the register-port mux and MISO.
module spi_slave_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_sck,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_rd_stb,
    output logic [7:0]        o_wr_data,
    output logic              o_wr_stb,
    output logic              o_busy,
    output logic              o_frame_err
);

    // state     | meaning
    // S_IDLE    | no frame; waiting for CS_n fall (only once CS_n has been seen high)
    // S_CMD     | shifting in the command byte
    // S_WR_DATA | shifting in write bytes, strobing each completed byte
    // S_RD_DATA | shifting read bytes out on MISO, reloading tx_sr per byte
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR_DATA, S_RD_DATA} state_t;

    localparam logic [2:0] FLUSH_N = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [2:0]             flush_cnt_q, flush_cnt_d;
    logic                   armed_q, armed_d;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_sr_q, rx_sr_d;
    logic [7:0]             tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   wr_pend_q, wr_pend_d;
    logic                   wr_stb_q, wr_stb_d;
    logic                   ld_pend_q, ld_pend_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   rd_stb_q, rd_stb_d;
    logic                   miso_q, miso_d;
    logic                   frame_err_q, frame_err_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall;
    logic       flush_done;
    logic       load;
    logic [7:0] rx_next;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign flush_done = (flush_cnt_q == FLUSH_N);
    assign rx_next    = {rx_sr_q[6:0], mosi_s};

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
        sck_prev_d  = sck_s;
        flush_cnt_d = flush_done ? flush_cnt_q : flush_cnt_q + 3'd1;
        // The chain resets to CS_n=1, so only trust a high CS_n once the real pin has flushed through.
        armed_d     = armed_q | (flush_done & cs_s);

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_pend_d   = 1'b0;
        ld_pend_d   = 1'b0;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        load        = 1'b0;

        if (state_q == S_IDLE) begin
            bit_cnt_d = 3'd0;
            rx_sr_d   = 8'd0;
            miso_d    = 1'b0;
            if (armed_q && !cs_s) begin
                state_d = S_CMD;
            end
        end else if (cs_s) begin
            // CS_n wins over a coincident SCK edge; a tie with the 8th rise is treated as a clean end.
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            if (bit_cnt_q != 3'd0 && !(sck_rise && bit_cnt_q == 3'd7)) begin
                frame_err_d = 1'b1;
            end
        end else begin
            if (ld_pend_q) begin
                load = 1'b1;
            end
            if (sck_rise) begin
                rx_sr_d   = rx_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        S_CMD: begin
                            addr_d = rx_next[ADDR_W-1:0];
                            if (rx_next[7]) begin
                                state_d   = S_RD_DATA;
                                ld_pend_d = 1'b1;
                            end else begin
                                state_d = S_WR_DATA;
                            end
                        end
                        S_WR_DATA: begin
                            wr_data_d = rx_next;
                            wr_pend_d = 1'b1;
                        end
                        S_RD_DATA: load = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (state_q == S_RD_DATA) begin
                if (sck_fall) begin
                    miso_d  = tx_sr_q[7];
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end else begin
                miso_d = 1'b0;
            end
            if (load) begin
                tx_sr_d = i_rd_data;
            end
        end

        rd_pend_d = load;
        // Strobes are dropped rather than issued once the frame has already closed.
        wr_stb_d  = wr_pend_q & (state_d != S_IDLE);
        rd_stb_d  = rd_pend_q & (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            flush_cnt_q <= 3'd0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 8'd0;
            tx_sr_q     <= 8'd0;
            addr_q      <= '0;
            wr_data_q   <= 8'd0;
            wr_pend_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            ld_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_stb_q    <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            flush_cnt_q <= flush_cnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_pend_q   <= wr_pend_d;
            wr_stb_q    <= wr_stb_d;
            ld_pend_q   <= ld_pend_d;
            rd_pend_q   <= rd_pend_d;
            rd_stb_q    <= rd_stb_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = (state_q != S_IDLE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_addr        = addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_wr_stb      = wr_stb_q;
    assign o_rd_stb      = rd_stb_q;
    assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: drives SPI mode-0 frames; a scoreboard monitor checks write bytes,
// MISO read bytes and strobe rules against queued expectations.
module tb_spi_slave_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [1:0] addr;
    logic [7:0] rd_data;
    logic       rd_stb;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic       busy;
    logic       frame_err;

    spi_slave_frame #(.SYNC_STAGES(2), .ADDR_W(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_spi_sck    (spi_sck),
        .i_spi_cs_n   (spi_cs_n),
        .i_spi_mosi   (spi_mosi),
        .o_spi_miso   (spi_miso),
        .o_spi_miso_oe(spi_miso_oe),
        .o_addr       (addr),
        .i_rd_data    (rd_data),
        .o_rd_stb     (rd_stb),
        .o_wr_data    (wr_data),
        .o_wr_stb     (wr_stb),
        .o_busy       (busy),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_wr = 0;
    int cnt_rd = 0;
    int cnt_err = 0;
    int rd_base = 0;
    int half = 6;
    logic mon_rd = 1'b0;
    logic [7:0] rd_tbl [32];
    logic [4:0] rd_idx;
    logic [7:0] exp_wr[$];
    logic [7:0] exp_miso[$];
    logic [7:0] miso_sh = 8'd0;
    int miso_bits = 0;

    assign rd_idx  = 5'(cnt_rd - rd_base);
    assign rd_data = rd_tbl[rd_idx];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Strobe monitor: pops the expected write byte for every o_wr_stb.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_stb) begin
                cnt_wr++;
                if (exp_wr.size() == 0) begin
                    chk("wr_stb_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
                end else begin
                    chk("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
                end
                chk("wr_stb_busy_no_rd", {30'd0, busy, rd_stb}, 32'd2);
            end
            if (rd_stb) begin
                cnt_rd++;
                chk("rd_stb_busy_no_wr", {30'd0, busy, wr_stb}, 32'd2);
            end
            if (frame_err) cnt_err++;
        end
    end

    // MISO monitor: assembles bytes on master sampling rises during read data phases.
    always @(posedge spi_sck) begin
        if (mon_rd) begin
            miso_sh = {miso_sh[6:0], spi_miso};
            miso_bits++;
            if (miso_bits == 8) begin
                miso_bits = 0;
                if (exp_miso.size() == 0) begin
                    chk("miso_unexpected", 32'(miso_sh), 32'hFFFF_FFFF);
                end else begin
                    chk("miso_byte", 32'(miso_sh), 32'(exp_miso.pop_front()));
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        wclk(half);
        spi_sck = 1'b1;
        wclk(half);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wclk(half);
    endtask

    task automatic cs_high();
        wclk(half);
        spi_cs_n = 1'b1;
        wclk(8);
    endtask

    int wr0, rd0, er0;
    logic [7:0] v;

    initial begin
        for (int i = 0; i < 32; i++) rd_tbl[i] = 8'd0;
        rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        wclk(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", 32'(spi_miso_oe), 0);
        chk("rst_miso", 32'(spi_miso), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_strobes", {29'd0, wr_stb, rd_stb, frame_err}, 0);
        rst_n = 1'b1;
        wclk(10);

        // write frame 0x01 A5 5A
        wr0 = cnt_wr; rd0 = cnt_rd;
        exp_wr.push_back(8'hA5); exp_wr.push_back(8'h5A);
        cs_low();
        spi_byte(8'h01); chk("wr_busy_cmd", 32'(busy), 1);
        spi_byte(8'hA5); chk("wr_busy_b1", 32'(busy), 1);
        spi_byte(8'h5A); chk("wr_busy_b2", 32'(busy), 1);
        cs_high();
        chk("wr_addr", 32'(addr), 1);
        chk("wr_count", 32'(cnt_wr - wr0), 2);
        chk("wr_no_rd", 32'(cnt_rd - rd0), 0);
        chk("wr_hold_data", 32'(wr_data), 32'h5A);
        chk("wr_idle_busy", 32'(busy), 0);

        // read frame 0x83 + 2 dummies
        wr0 = cnt_wr; rd0 = cnt_rd; rd_base = cnt_rd;
        rd_tbl[0] = 8'hC3; rd_tbl[1] = 8'h81; rd_tbl[2] = 8'h00;
        exp_miso.push_back(8'hC3); exp_miso.push_back(8'h81);
        cs_low();
        spi_byte(8'h83);
        mon_rd = 1'b1;
        spi_byte(8'h00); spi_byte(8'h00);
        mon_rd = 1'b0;
        cs_high();
        chk("rd_addr", 32'(addr), 3);
        chk("rd_count", 32'(cnt_rd - rd0), 3);
        chk("rd_no_wr", 32'(cnt_wr - wr0), 0);
        chk("rd_miso_left", 32'(exp_miso.size()), 0);
        chk("rd_idle_oe", 32'(spi_miso_oe), 0);

        // frame error: CS_n rises after 4 bits of a write data byte
        wr0 = cnt_wr; er0 = cnt_err;
        cs_low();
        spi_byte(8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        cs_high();
        chk("ferr_count", 32'(cnt_err - er0), 1);
        chk("ferr_no_wr", 32'(cnt_wr - wr0), 0);
        chk("ferr_wr_data", 32'(wr_data), 32'h5A);
        chk("ferr_oe", 32'(spi_miso_oe), 0);

        // tie: CS_n rise together with the 8th SCK rise of a write byte
        wr0 = cnt_wr; er0 = cnt_err;
        cs_low();
        spi_byte(8'h00);
        v = 8'h3C;
        for (int i = 7; i >= 1; i--) spi_bit(v[i]);
        spi_mosi = v[0];
        wclk(half);
        spi_sck = 1'b1; spi_cs_n = 1'b1;
        wclk(half);
        spi_sck = 1'b0;
        wclk(8);
        chk("tie_no_wr", 32'(cnt_wr - wr0), 0);
        chk("tie_no_err", 32'(cnt_err - er0), 0);
        chk("tie_idle", 32'(busy), 0);

        // reset mid-frame, release with CS_n low: frame must be ignored
        wr0 = cnt_wr; rd0 = cnt_rd;
        cs_low();
        v = 8'h02;
        for (int i = 7; i >= 3; i--) spi_bit(v[i]);
        rst_n = 1'b0;
        wclk(3);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        rst_n = 1'b1;
        v = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(v[i]);
            chk("resync_oe", 32'(spi_miso_oe), 0);
        end
        spi_byte(8'h77);
        chk("resync_busy", 32'(busy), 0);
        chk("resync_no_stb", 32'((cnt_wr - wr0) + (cnt_rd - rd0)), 0);
        cs_high();
        exp_wr.push_back(8'h3C);
        cs_low();
        spi_byte(8'h02); spi_byte(8'h3C);
        cs_high();
        chk("resync_addr", 32'(addr), 2);
        chk("resync_wr_count", 32'(cnt_wr - wr0), 1);
        chk("resync_wr_data", 32'(wr_data), 32'h3C);

        // minimum SCK high/low, 16-byte read of port 0
        half = 4;
        rd0 = cnt_rd; rd_base = cnt_rd;
        for (int i = 0; i < 32; i++) rd_tbl[i] = 8'(i);
        for (int i = 0; i < 16; i++) exp_miso.push_back(8'(i));
        cs_low();
        spi_byte(8'h80);
        mon_rd = 1'b1;
        for (int i = 0; i < 16; i++) spi_byte(8'h00);
        mon_rd = 1'b0;
        cs_high();
        chk("burst_addr", 32'(addr), 0);
        chk("burst_rd_count", 32'(cnt_rd - rd0), 17);
        chk("burst_miso_left", 32'(exp_miso.size()), 0);
        chk("wr_queue_left", 32'(exp_wr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
